// File: rtl/ram_burst.sv
// rtl/ram_burst.sv - word-wide byte-lane RAM with valid/ready incrementing burst reads and writes
// Optional macro RAM_OUTREG_EN adds a read pipeline stage (2-cycle read latency).
module ram_burst #(
    parameter int ADDR_WIDTH = 17,
    parameter int LANES      = 4,
    parameter int BURST_W    = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_we_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [BURST_W-1:0]    req_len_in,
    input  logic [LANES-1:0]      req_be_in,
    input  logic [8*LANES-1:0]    wdata_in,
    input  logic                  wvalid_in,
    output logic                  wready_out,
    output logic [8*LANES-1:0]    rdata_out,
    output logic                  rvalid_out,
    output logic                  rlast_out,
    output logic                  busy_out
);

    localparam int OFFS  = $clog2(LANES);
    localparam int WA    = ADDR_WIDTH - OFFS;
    localparam int WORDS = 1 << WA;
    localparam int DW    = 8 * LANES;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t              state_q, state_d;
    logic [WA-1:0]       addr_q;
    logic [BURST_W-1:0]  cnt_q;
    logic [BURST_W-1:0]  len_q;
    logic [LANES-1:0]    be_q;
    logic                load;
    logic                issue;
    logic                wr_beat;
    logic                last;

    logic [DW-1:0]       mem [WORDS];

    logic [DW-1:0]       s1_data;
    logic                s1_valid;
    logic                s1_last;

    assign last = (cnt_q == len_q);

    // The final read issue cycle also accepts a new request so bursts chain without a bubble.
    always_comb begin
        state_d       = state_q;
        req_ready_out = 1'b0;
        wready_out    = 1'b0;
        load          = 1'b0;
        issue         = 1'b0;
        wr_beat       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_out = 1'b1;
                if (req_valid_in) begin
                    load    = 1'b1;
                    state_d = req_we_in ? WRITE : READ;
                end
            end
            READ: begin
                issue = 1'b1;
                if (last) begin
                    req_ready_out = 1'b1;
                    if (req_valid_in) begin
                        load    = 1'b1;
                        state_d = req_we_in ? WRITE : READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                wready_out = 1'b1;
                if (wvalid_in) begin
                    wr_beat = 1'b1;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            be_q     <= '0;
            busy_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_out <= (state_d != IDLE);
            if (load) begin
                addr_q <= req_addr_in[ADDR_WIDTH-1:OFFS];
                cnt_q  <= '0;
                len_q  <= req_len_in;
                be_q   <= req_be_in;
            end else if (issue || wr_beat) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    // Storage is never reset; only the lanes enabled for this burst are written.
    always_ff @(posedge clk_in) begin
        if (wr_beat) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= wdata_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_last  <= issue && last;
            if (issue) begin
                s1_data <= mem[addr_q];
            end
        end
    end

`ifdef RAM_OUTREG_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rdata_out  <= '0;
            rvalid_out <= 1'b0;
            rlast_out  <= 1'b0;
        end else begin
            rdata_out  <= s1_data;
            rvalid_out <= s1_valid;
            rlast_out  <= s1_last;
        end
    end
`else
    assign rdata_out  = s1_data;
    assign rvalid_out = s1_valid;
    assign rlast_out  = s1_last;
`endif

    // Sub-word address bits are ignored by design.
    if (OFFS > 0) begin : g_offs
        logic unused_offs;
        assign unused_offs = ^req_addr_in[OFFS-1:0];
    end

endmodule

// File: tb/tb_ram_burst.sv
// tb/tb_ram_burst.sv - randomized self-checking bench for ram_burst against a word-array model
module tb_ram_burst;

    localparam int WMASK = 32767;
`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [16:0] req_addr = '0;
    logic [2:0]  req_len = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        busy;

    ram_burst dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .req_valid_in (req_valid),
        .req_ready_out(req_ready),
        .req_we_in    (req_we),
        .req_addr_in  (req_addr),
        .req_len_in   (req_len),
        .req_be_in    (req_be),
        .wdata_in     (wdata),
        .wvalid_in    (wvalid),
        .wready_out   (wready),
        .rdata_out    (rdata),
        .rvalid_out   (rvalid),
        .rlast_out    (rlast),
        .busy_out     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] model [0:32767];
    logic [31:0] rq_data [$];
    logic        rq_last [$];
    int          rq_cyc  [$];

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            rq_data.push_back(rdata);
            rq_last.push_back(rlast);
            rq_cyc.push_back(cyc);
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wbuf [0:7];
    logic [31:0] last_rd;
    int          first_beat_cyc;
    int          last_beat_cyc;

    task automatic model_wr(input int word, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++)
            if (be[i]) model[word & WMASK][8*i +: 8] = d[8*i +: 8];
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic do_req(input bit we, input int word, input int len, input logic [3:0] be,
                          output int acc);
        int          guard;
        logic [14:0] w;
        guard     = 0;
        w         = word[14:0];
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = {w, 2'($urandom_range(0, 3))};
        req_len   = 3'(len);
        req_be    = be;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL req_accept: ready=%b, required 1 within 50 cycles", req_ready);
        end
        acc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic write_burst(input int word, input int len, input logic [3:0] be,
                               input logic [15:0] pat);
        int acc;
        int beats;
        int j;
        beats = 0;
        j     = 0;
        do_req(1'b1, word, len, be, acc);
        while (beats <= len && j < 100) begin
            logic v;
            v      = (j < 16) ? pat[j] : 1'b1;
            wvalid = v;
            wdata  = v ? wbuf[beats] : $urandom;
            if (v) begin
                n_cmp++;
                if (wready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wready_beat: got %b, required 1 (beat %0d)", wready, beats);
                end
            end
            @(negedge clk);
            if (v) begin
                model_wr(word + beats, wbuf[beats], be);
                beats++;
            end
            j++;
        end
        wvalid = 1'b0;
        n_cmp++;
        if (beats <= len) begin
            n_bad++;
            $display("FAIL write_done: beats=%0d, required %0d", beats, len + 1);
        end
    endtask

    task automatic read_check(input int acc, input int word, input int len);
        for (int k = 0; k <= len; k++) begin
            int          guard;
            logic [31:0] d;
            logic        l;
            int          c;
            guard = 0;
            while (rq_data.size() == 0 && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
            end
            n_cmp++;
            if (rq_data.size() == 0) begin
                n_bad++;
                $display("FAIL rbeat_timeout: no beat %0d of read at word %0d", k, word);
                return;
            end
            d = rq_data.pop_front();
            l = rq_last.pop_front();
            c = rq_cyc.pop_front();
            n_cmp++;
            if (d !== model[(word + k) & WMASK]) begin
                n_bad++;
                $display("FAIL rdata: got %h, required %h (word %0d)", d,
                         model[(word + k) & WMASK], (word + k) & WMASK);
            end
            n_cmp++;
            if (l !== (k == len)) begin
                n_bad++;
                $display("FAIL rlast: got %b, required %b (beat %0d)", l, (k == len), k);
            end
            n_cmp++;
            if (c !== acc + LAT + k) begin
                n_bad++;
                $display("FAIL rcycle: got %0d, required %0d (beat %0d)", c, acc + LAT + k, k);
            end
            if (k == 0) first_beat_cyc = c;
            last_beat_cyc = c;
            last_rd       = d;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b, required 1", req_ready); end
        n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL rst_wready: got %b, required 0", wready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b, required 0", rvalid); end
        n_cmp++; if (rlast !== 1'b0) begin n_bad++; $display("FAIL rst_rlast: got %b, required 0", rlast); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h, required 0", rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_and_be();
        int acc;
        wbuf[0] = 32'hDEADBEEF;
        write_burst(4, 0, 4'hF, 16'hFFFF);
        do_req(1'b0, 4, 0, 4'h0, acc);
        read_check(acc, 4, 0);
        n_cmp++; if (last_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_rd: got %h, required deadbeef", last_rd); end
        wbuf[0] = 32'h11223344;
        write_burst(4, 0, 4'b0101, 16'hFFFF);
        do_req(1'b0, 4, 0, 4'h0, acc);
        read_check(acc, 4, 0);
        n_cmp++; if (last_rd !== 32'hDE22BE44) begin n_bad++; $display("FAIL be_merge: got %h, required de22be44", last_rd); end
    endtask

    task automatic test_wrap();
        int acc;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        write_burst(32766, 3, 4'hF, 16'hFFFF);
        do_req(1'b0, 32766, 3, 4'h0, acc);
        read_check(acc, 32766, 3);
        do_req(1'b0, 0, 0, 4'h0, acc);
        read_check(acc, 0, 0);
        n_cmp++; if (last_rd !== 32'd3) begin n_bad++; $display("FAIL wrap_word0: got %h, required 3", last_rd); end
    endtask

    task automatic test_wvalid_gaps();
        int acc;
        for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
        write_burst(300, 4, 4'hF, 16'hFFFF);
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        write_burst(300, 3, 4'hF, 16'h0035);
        n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL gap_wready_drop: got %b, required 0", wready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gap_busy_clear: got %b, required 0", busy); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL gap_ready_back: got %b, required 1", req_ready); end
        do_req(1'b0, 300, 4, 4'h0, acc);
        read_check(acc, 300, 4);
    endtask

    task automatic test_back_to_back();
        int a1;
        int a2;
        int f1_last;
        do_req(1'b0, 300, 1, 4'h0, a1);
        do_req(1'b0, 302, 1, 4'h0, a2);
        read_check(a1, 300, 1);
        f1_last = last_beat_cyc;
        read_check(a2, 302, 1);
        n_cmp++;
        if (first_beat_cyc !== f1_last + 1) begin
            n_bad++;
            $display("FAIL b2b_bubble: second burst first beat at %0d, required %0d", first_beat_cyc, f1_last + 1);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (rq_data.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_extra_beats: got %0d, required 0", rq_data.size());
        end
    endtask

    task automatic test_reset_mid_write();
        int acc;
        int rel;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0A0_0000 + 32'(i);
        write_burst(200, 3, 4'hF, 16'hFFFF);
        do_req(1'b1, 200, 3, 4'hF, acc);
        for (int b = 0; b < 2; b++) begin
            logic [31:0] d;
            d      = $urandom;
            wvalid = 1'b1;
            wdata  = d;
            @(negedge clk);
            model_wr(200 + b, d, 4'hF);
        end
        wvalid = 1'b1;
        wdata  = $urandom;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL midrst_wready: got %b, required 0", wready); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b, required 1", req_ready); end
        @(negedge clk);
        wvalid = 1'b0;
        rst    = 1'b0;
        rel    = cyc;
        do_req(1'b0, 200, 3, 4'h0, acc);
        n_cmp++; if (acc !== rel + 1) begin n_bad++; $display("FAIL midrst_accept: accepted at %0d, required %0d", acc, rel + 1); end
        read_check(acc, 200, 3);
    endtask

    task automatic test_random();
        int acc;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
            write_burst(100 + 8 * b, 7, 4'hF, 16'hFFFF);
        end
        for (int op = 0; op < 40; op++) begin
            int len;
            int word;
            len  = $urandom_range(0, 7);
            word = 100 + $urandom_range(0, 63 - len);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
                write_burst(word, len, 4'($urandom), 16'($urandom));
            end else begin
                do_req(1'b0, word, len, 4'h0, acc);
                read_check(acc, word, len);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_and_be();
        test_wrap();
        test_wvalid_gaps();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
